// File: rtl/jtdd_vram_arb.sv
// jtdd_vram_arb: time-slot arbiter sharing one synchronous VRAM between the
// CPU and the video fetch logic. Each pixel-clock-enabled cycle, the lowest
// set bit of M selects a bus slot, and CPU_SLOTS marks which slots belong to
// the CPU. Video slots are always served.
//
// Optional feature macro: JTDD_BLANK_CPU_EN. When defined, video slots that
// fall in horizontal or vertical blanking are handed to the CPU.
//
// CPU handshake: cpu_req is a level request. Its address, data and direction
// are captured when the request is accepted. cpu_wait stays high while the
// request has not completed. cpu_ok pulses for one clk when the access is
// done, and cpu_dout is valid from that cycle on. Each access needs cpu_req
// to be low for at least one clk before a new access can start.
module jtdd_vram_arb #(
    parameter int          AW        = 12,
    parameter logic [5:0]  CPU_SLOTS = 6'b101010
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pxl_cen,
    input  logic [5:0]    M,
    input  logic          HBL,
    input  logic          VBL,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_din,
    output logic [7:0]    cpu_dout,
    output logic          cpu_ok,
    output logic          cpu_wait,
    input  logic [AW-1:0] vid_addr,
    output logic [7:0]    vid_dout,
    output logic          vid_ok,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [7:0]    ram_din,
    input  logic [7:0]    ram_dout,
    output logic [1:0]    dbg_state
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] PEND = 2'd1;
    localparam logic [1:0] ACC  = 2'd2;
    localparam logic [1:0] DATA = 2'd3;

    logic [1:0]    state;
    logic          armed;
    logic          lat_we;
    logic [AW-1:0] lat_addr;
    logic [7:0]    lat_din;
    logic          slot_hit;
    logic          slot_cpu;
    logic          grant_cpu;
    logic          grant_vid;
    logic [1:0]    vid_pipe;

    // Slot decode: lowest set bit of M picks the slot and its owner
    always_comb begin
        slot_hit = 1'b0;
        slot_cpu = 1'b0;
        for (int i = 5; i >= 0; i--) begin
            if (M[i]) begin
                slot_hit = 1'b1;
                slot_cpu = CPU_SLOTS[i];
            end
        end
`ifdef JTDD_BLANK_CPU_EN
        if (HBL || VBL) slot_cpu = 1'b1;
`endif
    end

`ifndef JTDD_BLANK_CPU_EN
    // Blanking flags only matter when blank slots go to the CPU
    logic unused_blank;
    assign unused_blank = HBL | VBL;
`endif

    assign grant_cpu = pxl_cen && slot_hit && slot_cpu && (state == PEND) && cpu_req;
    assign grant_vid = pxl_cen && slot_hit && !slot_cpu;

    assign cpu_wait  = cpu_req && ((state != IDLE) || armed) && !cpu_ok;
    assign dbg_state = state;

    // CPU access FSM, request latching and re-arm tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            armed    <= 1'b1;
            lat_we   <= 1'b0;
            lat_addr <= '0;
            lat_din  <= '0;
        end else begin
            if (!cpu_req) armed <= 1'b1;
            case (state)
                IDLE: begin
                    if (cpu_req && armed) begin
                        state    <= PEND;
                        armed    <= 1'b0;
                        lat_we   <= cpu_we;
                        lat_addr <= cpu_addr;
                        lat_din  <= cpu_din;
                    end
                end
                PEND: begin
                    if (!cpu_req)       state <= IDLE;
                    else if (grant_cpu) state <= ACC;
                end
                ACC:     state <= DATA;
                DATA:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // RAM port: address/data load on a grant; write strobe lasts one clk
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_addr <= '0;
            ram_we   <= 1'b0;
            ram_din  <= '0;
        end else begin
            ram_we <= 1'b0;
            if (grant_cpu) begin
                ram_addr <= lat_addr;
                ram_we   <= lat_we;
                ram_din  <= lat_din;
            end else if (grant_vid) begin
                ram_addr <= vid_addr;
            end
        end
    end

    // CPU completion: capture read data and pulse cpu_ok on leaving DATA
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_ok   <= 1'b0;
            cpu_dout <= '0;
        end else begin
            cpu_ok <= 1'b0;
            if (state == DATA) begin
                cpu_ok <= 1'b1;
                if (!lat_we) cpu_dout <= ram_dout;
            end
        end
    end

    // Video fetch pipeline: data captured two clk after the grant edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vid_pipe <= 2'b00;
            vid_ok   <= 1'b0;
            vid_dout <= '0;
        end else begin
            vid_pipe <= {vid_pipe[0], grant_vid};
            vid_ok   <= vid_pipe[1];
            if (vid_pipe[1]) vid_dout <= ram_dout;
        end
    end

endmodule

// File: tb/tb_jtdd_vram_arb.sv
// tb_jtdd_vram_arb: directed bench for jtdd_vram_arb with a synchronous
// RAM model and hand-computed expectations.
module tb_jtdd_vram_arb;

    localparam int AW = 12;
`ifdef JTDD_BLANK_CPU_EN
    localparam bit BLANK_EN = 1'b1;
`else
    localparam bit BLANK_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          pxl_cen;
    logic [5:0]    M;
    logic          HBL, VBL;
    logic          cpu_req, cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [7:0]    cpu_din;
    logic [7:0]    cpu_dout;
    logic          cpu_ok, cpu_wait;
    logic [AW-1:0] vid_addr;
    logic [7:0]    vid_dout;
    logic          vid_ok;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [7:0]    ram_din;
    logic [7:0]    ram_dout;
    logic [1:0]    dbg_state;

    logic [7:0]    mem [0:(1<<AW)-1];
    logic          tb_we;
    logic [AW-1:0] tb_a;
    logic [7:0]    tb_d;

    int n_assert = 0;
    int n_fail   = 0;
    int ok_cnt   = 0;
    int vid_cnt  = 0;
    int ok_base, vid_base;

    jtdd_vram_arb #(.AW(AW), .CPU_SLOTS(6'b101010)) dut (
        .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen), .M(M),
        .HBL(HBL), .VBL(VBL),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_dout(cpu_dout), .cpu_ok(cpu_ok), .cpu_wait(cpu_wait),
        .vid_addr(vid_addr), .vid_dout(vid_dout), .vid_ok(vid_ok),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout),
        .dbg_state(dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    // Synchronous single-port RAM with a bench-side preload port
    always @(posedge clk) begin
        if (tb_we)       mem[tb_a]     <= tb_d;
        else if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    // Completion pulse counters
    always @(posedge clk) begin
        if (cpu_ok) ok_cnt++;
        if (vid_ok) vid_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic poke(input logic [AW-1:0] a, input logic [7:0] d);
        tb_we = 1'b1; tb_a = a; tb_d = d;
        tick(1);
        tb_we = 1'b0;
    endtask

    // One pxl_cen pulse carrying slot strobes m; returns one negedge later
    task automatic do_slot(input logic [5:0] m);
        pxl_cen = 1'b1; M = m;
        tick(1);
        pxl_cen = 1'b0; M = 6'd0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; pxl_cen = 1'b0; M = 6'd0; HBL = 1'b0; VBL = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_din = '0;
        vid_addr = 12'h200; tb_we = 1'b0; tb_a = '0; tb_d = '0;
        tick(2);

        // Reset state
        check("rst state",    dbg_state, 0);
        check("rst cpu_ok",   cpu_ok,    0);
        check("rst cpu_dout", cpu_dout,  0);
        check("rst vid_ok",   vid_ok,    0);
        check("rst vid_dout", vid_dout,  0);
        check("rst ram_addr", ram_addr,  0);
        check("rst ram_we",   ram_we,    0);
        check("rst ram_din",  ram_din,   0);
        check("rst cpu_wait", cpu_wait,  0);

        poke(12'h123, 8'h5A);
        poke(12'h200, 8'h77);
        poke(12'h055, 8'h11);
        poke(12'h0FF, 8'h00);
        rst_n = 1'b1;
        tick(1);

        // CPU read in slot M[1]
        cpu_addr = 12'h123; cpu_we = 1'b0; cpu_req = 1'b1;
        #1 check("rd wait early", cpu_wait, 1);
        tick(1);
        check("rd pend", dbg_state, 1);
        do_slot(6'b000010);
        check("rd ram_addr", ram_addr, 12'h123);
        check("rd ram_we",   ram_we,   0);
        tick(1);
        check("rd ok early", cpu_ok, 0);
        tick(1);
        check("rd ok",    cpu_ok,   1);
        check("rd dout",  cpu_dout, 8'h5A);
        check("rd wait",  cpu_wait, 0);
        cpu_req = 1'b0;
        tick(1);
        check("rd ok pulse", cpu_ok, 0);

        // CPU write in slot M[3]
        cpu_we = 1'b1; cpu_addr = 12'h0FF; cpu_din = 8'hC3; cpu_req = 1'b1;
        tick(1);
        do_slot(6'b001000);
        check("wr ram_we",   ram_we,   1);
        check("wr ram_din",  ram_din,  8'hC3);
        check("wr ram_addr", ram_addr, 12'h0FF);
        tick(1);
        check("wr we drop",  ram_we,   0);
        check("wr mem",      mem[12'h0FF], 8'hC3);
        tick(1);
        check("wr ok",       cpu_ok,   1);
        check("wr dout held", cpu_dout, 8'h5A);
        cpu_req = 1'b0;
        tick(1);

        // Readback
        cpu_we = 1'b0; cpu_req = 1'b1;
        tick(1);
        do_slot(6'b000010);
        tick(2);
        check("rb ok",   cpu_ok,   1);
        check("rb dout", cpu_dout, 8'hC3);
        cpu_req = 1'b0;
        tick(1);

        // Contention: slots 0..5 with CPU pending
        ok_base = ok_cnt; vid_base = vid_cnt;
        cpu_addr = 12'h123; cpu_req = 1'b1;
        tick(1);
        do_slot(6'b000001);
        check("ct0 ram_addr", ram_addr, 12'h200);
        tick(2);
        check("ct0 vid_ok",   vid_ok,    1);
        check("ct0 vid_dout", vid_dout,  8'h77);
        check("ct0 pend",     dbg_state, 1);
        tick(1);
        do_slot(6'b000010);
        check("ct1 ram_addr", ram_addr, 12'h123);
        tick(2);
        check("ct1 cpu_ok", cpu_ok,   1);
        check("ct1 dout",   cpu_dout, 8'h5A);
        check("ct1 vid_ok", vid_ok,   0);
        cpu_req = 1'b0;
        tick(1);
        do_slot(6'b000100);
        tick(2);
        check("ct2 vid_ok", vid_ok, 1);
        tick(1);
        do_slot(6'b001000);
        check("ct3 addr held", ram_addr, 12'h200);
        check("ct3 we",        ram_we,   0);
        tick(3);
        do_slot(6'b010000);
        tick(2);
        check("ct4 vid_ok", vid_ok, 1);
        tick(1);
        do_slot(6'b100000);
        tick(2);
        check("ct5 vid_ok", vid_ok, 0);
        tick(1);
        check("ct vid count", vid_cnt - vid_base, 3);
        check("ct ok count",  ok_cnt - ok_base,   1);

        // Lowest set bit wins
        cpu_addr = 12'h0FF; cpu_req = 1'b1;
        tick(1);
        do_slot(6'b011010);
        check("lsb cpu addr", ram_addr, 12'h0FF);
        tick(2);
        check("lsb cpu ok", cpu_ok,   1);
        check("lsb dout",   cpu_dout, 8'hC3);
        cpu_req = 1'b0;
        tick(1);
        do_slot(6'b101100);
        check("lsb vid addr", ram_addr, 12'h200);
        tick(2);
        check("lsb vid ok", vid_ok, 1);
        tick(1);

        // M=0 grants nothing; drop in PEND aborts
        ok_base = ok_cnt;
        cpu_addr = 12'h123; cpu_req = 1'b1;
        tick(1);
        do_slot(6'b000000);
        tick(2);
        check("m0 pend",   dbg_state, 1);
        check("m0 cpu_ok", cpu_ok,    0);
        cpu_req = 1'b0;
        tick(1);
        check("abort idle", dbg_state, 0);
        check("abort wait", cpu_wait,  0);
        do_slot(6'b000010);
        tick(2);
        check("abort no ram", ram_addr, 12'h200);
        tick(1);
        check("abort no ok", ok_cnt - ok_base, 0);

        // Held request: one access only; re-arm gives a second
        ok_base = ok_cnt;
        cpu_req = 1'b1;
        tick(1);
        repeat (10) begin
            do_slot(6'b000010);
            tick(3);
        end
        check("held one ok", ok_cnt - ok_base, 1);
        check("held wait",   cpu_wait, 0);
        cpu_req = 1'b0;
        tick(1);
        cpu_req = 1'b1;
        tick(1);
        do_slot(6'b000010);
        tick(3);
        check("rearm ok", ok_cnt - ok_base, 2);
        cpu_req = 1'b0;
        tick(1);

        // Reset during ACC of a write
        ok_base = ok_cnt; vid_base = vid_cnt;
        cpu_we = 1'b1; cpu_addr = 12'h055; cpu_din = 8'hEE; cpu_req = 1'b1;
        tick(1);
        do_slot(6'b001000);
        check("mid acc we", ram_we, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid rst we",    ram_we,    0);
        check("mid rst state", dbg_state, 0);
        cpu_req = 1'b0; cpu_we = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(4);
        check("mid rst no ok",  ok_cnt - ok_base,   0);
        check("mid rst no vid", vid_cnt - vid_base, 0);
        check("mid rst mem",    mem[12'h055], 8'h11);

        // Blanking slot ownership
        HBL = 1'b1;
        cpu_addr = 12'h123; cpu_req = 1'b1;
        tick(1);
        do_slot(6'b000001);
        check("blk ram_addr", ram_addr, BLANK_EN ? 32'h123 : 32'h200);
        tick(2);
        check("blk vid_ok", vid_ok, BLANK_EN ? 0 : 1);
        check("blk cpu_ok", cpu_ok, BLANK_EN ? 1 : 0);
        tick(1);
        do_slot(6'b000010);
        tick(2);
        check("blk m1 cpu_ok", cpu_ok, BLANK_EN ? 0 : 1);
        cpu_req = 1'b0; HBL = 1'b0;
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
